rr_mux_reg: RTL
===============

# rr_mux_reg

Parametrised, registered N-channel multiplexer with round-robin arbitration and valid/ready handshaking on every channel and on the output. Generalises the 5-bit 2:1 selector used in the datapath to CHANNELS inputs of WIDTH bits. It adds a one-entry output register, fair arbitration and a forced-select override mode. It sits between multiple producers, such as writeback or forwarding sources, and a single consumer stage.

## Interface
- WIDTH, 5, data width per channel (≥1)
- CHANNELS, 4, number of input channels (≥2)
- SELW, $clog2(CHANNELS), width of channel index (derived, not overridden)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  CHANNELS  per-channel request
- in_ready  out  CHANNELS  per-channel accept; one-hot or zero
- force_en  in  1  1 = forced-select mode, arbitration bypassed
- force_sel  in  SELW  channel served while force_en=1
- out_data  out  WIDTH  registered selected data
- out_chan  out  SELW  index of channel held in output register
- out_valid  out  1  output register holds data
- out_ready  in  1  consumer accept

## Operation
- Single clock domain. Reset is asynchronous and active-low. It is the only reset.
- Output register: one entry. load_en = !out_valid | out_ready.
- Round-robin arbitration, force_en=0:
  - Pointer ptr (SELW bits) names the highest-priority channel.
  - Search ptr, ptr+1, …, wrapping modulo CHANNELS. The first channel with in_valid=1 wins.
- Forced mode, force_en=1:
  - Winner = force_sel if in_valid[force_sel]=1. Otherwise no winner.
  - Other channels are never granted.
  - force_sel ≥ CHANNELS means no winner.
- in_ready[i] = load_en & (winner==i). This is combinational from in_valid, force_en, force_sel, out_ready, out_valid and ptr.
- Transfer on channel i when in_valid[i] & in_ready[i]:
  - out_data ← in_data[i]
  - out_chan ← i
  - out_valid ← 1
  - In round-robin mode, ptr ← (i+1) mod CHANNELS.
- Forced-mode transfers do not update ptr. Round-robin resumes from the prior ptr.
- Output drains on out_valid & out_ready:
  - If no transfer occurs the same cycle, out_valid ← 0.
  - out_data and out_chan hold their last value.
- Simultaneous drain and load: the new word replaces the old in the same edge, giving full throughput.
- out_valid=1 and out_ready=0: the register holds, all in_ready=0, and out_data, out_chan and out_valid are stable.
- in_valid dropping without a transfer is legal. Arbitration re-evaluates every cycle, with no lock.
- Arithmetic: ptr increment wraps at CHANNELS, not 2^SELW. Non-power-of-2 CHANNELS must be supported.

## Timing
- Reset values: out_valid=0, out_data=0, out_chan=0, ptr=0. Reset holds in_ready all-zero only through load_en's dependence on winner; in_ready may assert during reset if in_valid is high. Consumers must not sample it while rst_n=0.
- Reset assertion mid-transfer clears the output register immediately, asynchronously. The pending word is lost.
- Latency: input accepted at edge N appears on out_data/out_valid after edge N, i.e. 1 cycle.
- Throughput: one word per cycle while out_ready=1.
- Combinational paths: out_ready→in_ready and in_valid→in_ready. There is no combinational path from in_* to out_*.
- Fairness: with all CHANNELS valid and out_ready=1, each channel is granted exactly once per CHANNELS consecutive cycles.

## Test plan
- Reset: drive rst_n=0 mid-stream with out_valid=1 → out_valid=0, out_data=0, out_chan=0 immediately. After release, first grant goes to ch0 when all are valid.
- Round-robin, defaults: in_data = {5'h04,5'h03,5'h02,5'h01} for ch3…ch0, all valid, out_ready=1.
  - out_data sequence 01,02,03,04,01 on consecutive cycles.
  - out_chan 0,1,2,3,0.
- Sparse requests: only ch1 and ch3 valid, ptr=2 → ch3 granted first, then ch1, then ch3. in_ready[0] and in_ready[2] remain 0.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles, all in_valid=1.
  - in_ready=0, and out_data is unchanged throughout.
  - On out_ready=1, the next word loads in the same edge and out_valid stays 1.
- Forced mode: force_en=1, force_sel=2, all valid.
  - Only ch2 is accepted, every cycle.
  - After force_en=0, round-robin continues from the pre-force ptr.
  - force_sel=2 with in_valid[2]=0 → no transfer, out_valid falls after drain.
- Non-power-of-2: CHANNELS=3, WIDTH=8, all valid → out_chan cycles 0,1,2,0. It never reaches 3.

Source files
------------

// File: rtl/rr_mux_reg.sv
`default_nettype none
// =============================================================================
// Module   : rr_mux_reg
// Brief    : N-channel round-robin multiplexer with a one-entry registered
//            valid/ready output stage and a forced-select override.
// Revision : 1.0  initial release
// =============================================================================
module rr_mux_reg #(
    parameter  int WIDTH    = 5,
    parameter  int CHANNELS = 4,
    localparam int SELW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      force_en,
    input  logic [SELW-1:0]           force_sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [SELW-1:0]       r_ptr;
    logic [WIDTH-1:0]      r_out_data;
    logic [SELW-1:0]       r_out_chan;
    logic                  r_out_valid;

    logic [2*CHANNELS-1:0] w_req2;
    logic                  w_rr_found;
    logic [SELW-1:0]       w_rr_idx;
    logic                  w_force_hit;
    logic                  w_win_valid;
    logic [SELW-1:0]       w_win_idx;
    logic [WIDTH-1:0]      w_win_data;
    logic                  w_load_en;
    logic                  w_xfer;
    logic [SELW-1:0]       w_ptr_next;

    // Doubled request vector: scanning upward from ptr covers the wrap-around
    // without any modulo arithmetic, so non-power-of-2 CHANNELS just works.
    assign w_req2 = {in_valid, in_valid};

    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        for (int j = 0; j < 2*CHANNELS; j++) begin
            if (!w_rr_found && (j >= int'(r_ptr)) && w_req2[j]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = (j >= CHANNELS) ? SELW'(j - CHANNELS) : SELW'(j);
            end
        end
    end

    // An out-of-range force_sel matches no channel and therefore never wins.
    always_comb begin
        w_force_hit = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (force_sel == SELW'(i)) begin
                w_force_hit = in_valid[i];
            end
        end
    end

    assign w_win_valid = force_en ? w_force_hit : w_rr_found;
    assign w_win_idx   = force_en ? force_sel   : w_rr_idx;
    assign w_load_en   = !r_out_valid || out_ready;
    assign w_xfer      = w_load_en && w_win_valid;
    assign w_ptr_next  = (w_win_idx == SELW'(CHANNELS - 1)) ? '0 : w_win_idx + SELW'(1);

    always_comb begin
        w_win_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_win_idx == SELW'(i)) begin
                w_win_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready[i] = w_xfer && (w_win_idx == SELW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_xfer) begin
            r_out_data  <= w_win_data;
            r_out_chan  <= w_win_idx;
            r_out_valid <= 1'b1;
            // Forced grants leave the fairness pointer untouched.
            if (!force_en) begin
                r_ptr <= w_ptr_next;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire
